serial_receiver: RTL

- Downstream stage of the serial transceiver.
- Captures the transceiver's serial bit stream, bit clock and busy (frame) indication, and deserializes each frame into a DATA_WIDTH-bit word.
- Presents each word to the consumer with a valid/ack handshake, and flags truncated frames and overruns.
- Runs entirely on the system clock: the serial clock and frame inputs are synchronized internally and edge-detected.

---
 rtl/serial_receiver.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// serial_receiver: deserializes the transceiver's framed, MSB-first bit stream
// into DATA_WIDTH-bit words. Everything runs on Clk. ClkSerial, SerialIn and
// FrameIn are synchronized and edge-detected here. Words go to the consumer
// through a valid/ack handshake, with sticky frame-error and overrun flags.
module serial_receiver #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SerialIn,
  input  logic                  ClkSerial,
  input  logic                  FrameIn,
  input  logic                  DataAck,
  input  logic                  ClearErr,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  output logic                  RxBusy,
  output logic                  RxDone,
  output logic                  FrameError,
  output logic                  Overrun
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned FW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DATA_WIDTH);
  localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_END} state_t;

  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_ser_sync, r_clk_sync, r_frm_sync;
  logic                   r_ser_d, r_clk_d, r_frm_d;
  logic                   r_clk_rise, r_frm_rise;
  logic [FW-1:0]          r_flush;
  logic                   r_armed;
  logic [CW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;

  logic                   w_frm_start;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_clear, w_capture, w_done, w_ferr, w_load;

  // Synchronizer chains. All three inputs go through the same depth so they stay aligned.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ser_sync <= '0;
      r_clk_sync <= '0;
      r_frm_sync <= '0;
    end else begin
      r_ser_sync <= {r_ser_sync[SYNC_STAGES-2:0], SerialIn};
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ClkSerial};
      r_frm_sync <= {r_frm_sync[SYNC_STAGES-2:0], FrameIn};
    end
  end

  // Registered edge detection. The delayed copies double as the data and
  // frame levels, so they line up with the edge pulses.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ser_d    <= 1'b0;
      r_clk_d    <= 1'b0;
      r_frm_d    <= 1'b0;
      r_clk_rise <= 1'b0;
      r_frm_rise <= 1'b0;
    end else begin
      r_ser_d    <= r_ser_sync[SYNC_STAGES-1];
      r_clk_d    <= r_clk_sync[SYNC_STAGES-1];
      r_frm_d    <= r_frm_sync[SYNC_STAGES-1];
      r_clk_rise <= r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
      r_frm_rise <= r_frm_sync[SYNC_STAGES-1] & ~r_frm_d;
    end
  end

  // Arming after reset. The zeroed synchronizers would make a frame that is
  // already in progress look like a fresh rising edge. So frame starts are
  // ignored until the chain has flushed and FrameIn has been seen low.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      if (r_flush != FLUSH_DONE)
        r_flush <= r_flush + FW'(1);
      if (r_flush == FLUSH_DONE && !r_frm_d)
        r_armed <= 1'b1;
    end
  end

  assign w_frm_start = r_frm_rise & r_armed;
  assign w_cnt_next  = r_cnt + CW'(1);

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_frm_start) w_state_next = RECEIVE;
      RECEIVE: begin
        if (r_cnt == CNT_FULL) w_state_next = WAIT_END;
        else if (w_ferr)       w_state_next = IDLE;
      end
      WAIT_END: if (!r_frm_d) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // FSM outputs. A bit edge in the same cycle as the frame-end check is
  // counted first, so a frame ending on its final bit is not an error.
  always_comb begin
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
    RxBusy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_frm_start) begin
          w_clear   = 1'b1;
          w_capture = r_clk_rise;
        end
      end
      RECEIVE: begin
        RxBusy = 1'b1;
        if (r_cnt == CNT_FULL) begin
          w_done = 1'b1;
        end else begin
          w_capture = r_clk_rise;
          if (!r_frm_d && ((r_clk_rise ? w_cnt_next : r_cnt) < CNT_FULL))
            w_ferr = 1'b1;
        end
      end
      WAIT_END: RxBusy = 1'b1;
      default:  RxBusy = 1'b0;
    endcase
  end

  // Bit counter and MSB-first shift register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_clear) begin
      if (w_capture) begin
        r_cnt   <= CW'(1);
        r_shift <= DATA_WIDTH'(r_ser_d);
      end else begin
        r_cnt   <= '0;
        r_shift <= '0;
      end
    end else if (w_capture) begin
      r_cnt   <= w_cnt_next;
      r_shift <= {r_shift[DATA_WIDTH-2:0], r_ser_d};
    end
  end

  assign w_load = w_done & (~DataValid | DataAck);

  // Output word, handshake, done pulse and sticky flags. A flag being set wins over ClearErr.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DataOut    <= '0;
      DataValid  <= 1'b0;
      RxDone     <= 1'b0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      RxDone <= w_done;
      if (w_load) begin
        DataOut   <= r_shift;
        DataValid <= 1'b1;
      end else if (DataAck) begin
        DataValid <= 1'b0;
      end
      if (w_done && DataValid && !DataAck) Overrun <= 1'b1;
      else if (ClearErr)                   Overrun <= 1'b0;
      if (w_ferr)        FrameError <= 1'b1;
      else if (ClearErr) FrameError <= 1'b0;
    end
  end

endmodule
